fila_arbiter: RTL and testbench
===============================

FILA_ARBITER -- requirements
Module: fila_arbiter

Interface
REQ-001 The block SHALL have these ports: clock_10KHz  in  1  sole clock, all logic on its rising edge.
REQ-002 The block SHALL have these ports: reset  in  1  synchronous, active-low reset.
REQ-003 The block SHALL have these ports: prod0_req_in / prod1_req_in  in  1  level enqueue requests, held until granted.
REQ-004 The block SHALL have these ports: prod0_data_in / prod1_data_in  in  8  producer payloads, stable while the request is high.
REQ-005 The block SHALL have these ports: cons_req_in  in  1  level dequeue request, held until acknowledged.
REQ-006 The block SHALL have these ports: len_in  in  4  queue occupancy (0..8), and q_data_in  in  8  queue output data.
REQ-007 The block SHALL have these ports: enqueue_out, dequeue_out  out  1  one-cycle command pulses to the queue; q_wdata_out  out  8  payload to the queue.
REQ-008 The block SHALL have these ports: prod0_gnt_out, prod1_gnt_out, cons_ack_out, cons_err_out  out  1  one-cycle pulses; cons_data_out  out  8  dequeued byte; busy_out  out  1  operation in progress.

Function
REQ-009 The FSM SHALL have the states IDLE, ENQ_ISSUE, DEQ_ISSUE and WAIT.
REQ-010 In IDLE with no eligible request, all pulse outputs SHALL be 0 and busy_out SHALL be 0.
REQ-011 An enqueue request SHALL be eligible only when len_in < 8, and a dequeue request only when len_in > 0.
REQ-012 A dequeue request with len_in == 0 SHALL NOT issue dequeue_out; instead, cons_err_out and cons_ack_out SHALL pulse for one cycle, cons_data_out SHALL become 8'h00, and the FSM SHALL stay in IDLE.
REQ-013 When an eligible enqueue and an eligible dequeue are both present, the operation opposite to the last completed one SHALL win; after reset, dequeue SHALL win.
REQ-014 Producer selection SHALL follow the Configuration section.
REQ-015 In ENQ_ISSUE (1 cycle), enqueue_out = 1, q_wdata_out = the selected producer's data, and the matching prodN_gnt_out = 1; the next state SHALL be WAIT.
REQ-016 In DEQ_ISSUE (1 cycle), dequeue_out = 1; the next state SHALL be WAIT.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES = 3 cycles, counted with a 2-bit down-counter, so the queue returns to its idle state before the next command.
REQ-018 On the last WAIT cycle of a dequeue, cons_data_out SHALL register q_data_in and cons_ack_out SHALL pulse; the FSM SHALL then return to IDLE.
REQ-019 busy_out SHALL be 1 in ENQ_ISSUE, DEQ_ISSUE and WAIT.
REQ-020 Commands SHALL be spaced by at least 4 cycles, and enqueue_out / dequeue_out SHALL never both be high.
REQ-021 A request that drops before its grant SHALL be ignored without error.
REQ-022 Occupancy SHALL be read only from len_in; the block SHALL keep no copy of it.

Reset
REQ-023 On a clock edge with reset = 0, the FSM SHALL go to IDLE, the WAIT counter to 0 and the last-op and round-robin pointers to 0 (prod0 first), and all outputs SHALL go to 0, including cons_data_out and q_wdata_out.
REQ-024 A reset during ENQ_ISSUE, DEQ_ISSUE or WAIT SHALL abort the operation with no ack or grant pulse afterwards.

Configuration
REQ-025 The macro FILA_ARB_RR_EN SHALL control producer selection.
REQ-026 With FILA_ARB_RR_EN defined, selection SHALL be round-robin: the producer not granted last wins a tie.
REQ-027 Without FILA_ARB_RR_EN, prod0 SHALL always have fixed priority over prod1.

Structure
REQ-028 The package fila_pkg SHALL hold the state enum, WAIT_CYCLES = 3, QUEUE_DEPTH = 8 and the data width 8.
REQ-029 The two-requester pick logic SHALL be a sub-module fila_rr_pick, taking both requests, the pointer and the mode, and returning a one-hot select.

Verification
REQ-030 Scenario: reset = 0 for 2 cycles, then prod0_req_in = 1, data 8'h41, len_in = 0 -> enqueue_out pulses 1 cycle later, q_wdata_out = 8'h41, prod0_gnt_out pulses, busy_out stays high for 4 cycles.
REQ-031 Scenario: len_in = 3, q_data_in = 8'h5A, cons_req_in = 1 -> dequeue_out pulses; 3 cycles later cons_ack_out pulses and cons_data_out = 8'h5A.
REQ-032 Scenario: len_in = 0, cons_req_in = 1 -> cons_err_out and cons_ack_out pulse, cons_data_out = 8'h00, dequeue_out never asserted.
REQ-033 Scenario: len_in = 8, prod1_req_in = 1 -> no grant while full; after len_in drops to 7, prod1_gnt_out pulses.
REQ-034 Scenario: prod0 and prod1 held high with len_in = 2 -> with FILA_ARB_RR_EN, grants alternate 0,1,0,1; without it, only prod0 is granted.
REQ-035 Scenario: reset driven 0 during WAIT after dequeue_out -> no cons_ack_out, outputs 0, busy_out 0 on the next cycle.

Source files
------------

// File: rtl/fila_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fila_pkg                                                     |
// | Description : Shared types and constants for the fila queue arbiter.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fila_pkg;

    localparam int DATA_W      = 8;
    localparam int LEN_W       = 4;
    localparam int WAIT_CYCLES = 3;
    localparam int WAIT_CNT_W  = 2;
    localparam int QUEUE_DEPTH = 8;

    localparam logic OP_ENQ = 1'b0;
    localparam logic OP_DEQ = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ENQ_ISSUE = 2'd1,
        DEQ_ISSUE = 2'd2,
        WAIT      = 2'd3
    } fila_state_e;

endpackage
`default_nettype wire

// File: rtl/fila_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fila_rr_pick                                                 |
// | Description : Two-requester pick; one-hot select, round-robin or fixed.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fila_rr_pick (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_ptr,
    input  logic       i_rr_mode,
    output logic [1:0] o_sel
);

    // i_ptr names the preferred requester; it only matters on a tie in RR mode
    always_comb begin
        o_sel = 2'b00;
        if (i_req0 && i_req1) begin
            o_sel = (i_rr_mode && i_ptr) ? 2'b10 : 2'b01;
        end else if (i_req0) begin
            o_sel = 2'b01;
        end else if (i_req1) begin
            o_sel = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fila_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fila_arbiter                                                 |
// | Description : Arbitrates two producers and one consumer onto a queue.      |
// |               Define FILA_ARB_RR_EN for round-robin producer selection,    |
// |               otherwise prod0 has fixed priority.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fila_arbiter
    import fila_pkg::*;
(
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              prod0_req_in,
    input  logic              prod1_req_in,
    input  logic [DATA_W-1:0] prod0_data_in,
    input  logic [DATA_W-1:0] prod1_data_in,
    input  logic              cons_req_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] q_data_in,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] q_wdata_out,
    output logic              prod0_gnt_out,
    output logic              prod1_gnt_out,
    output logic              cons_ack_out,
    output logic              cons_err_out,
    output logic [DATA_W-1:0] cons_data_out,
    output logic              busy_out
);

`ifdef FILA_ARB_RR_EN
    localparam logic RR_MODE = 1'b1;
`else
    localparam logic RR_MODE = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    fila_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  last_op_q, last_op_d;
    logic                  cur_op_q, cur_op_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  enqueue_q, enqueue_d;
    logic                  dequeue_q, dequeue_d;
    logic [DATA_W-1:0]     q_wdata_q, q_wdata_d;
    logic                  prod0_gnt_q, prod0_gnt_d;
    logic                  prod1_gnt_q, prod1_gnt_d;
    logic                  cons_ack_q, cons_ack_d;
    logic                  cons_err_q, cons_err_d;
    logic [DATA_W-1:0]     cons_data_q, cons_data_d;
    logic                  busy_q, busy_d;

    logic                  w_enq_elig;
    logic                  w_deq_elig;
    logic [1:0]            w_pick_sel;

    assign w_enq_elig = (prod0_req_in || prod1_req_in) && (len_in < LEN_W'(QUEUE_DEPTH));
    assign w_deq_elig = cons_req_in && (len_in != '0);

    fila_rr_pick u_pick (
        .i_req0    (prod0_req_in),
        .i_req1    (prod1_req_in),
        .i_ptr     (rr_ptr_q),
        .i_rr_mode (RR_MODE),
        .o_sel     (w_pick_sel)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        last_op_d   = last_op_q;
        cur_op_d    = cur_op_q;
        rr_ptr_d    = rr_ptr_q;
        q_wdata_d   = q_wdata_q;
        cons_data_d = cons_data_q;
        enqueue_d   = 1'b0;
        dequeue_d   = 1'b0;
        prod0_gnt_d = 1'b0;
        prod1_gnt_d = 1'b0;
        cons_ack_d  = 1'b0;
        cons_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the operation opposite to the last completed one wins
                if (w_enq_elig && (!w_deq_elig || (last_op_q == OP_DEQ))) begin
                    state_d     = ENQ_ISSUE;
                    cur_op_d    = OP_ENQ;
                    enqueue_d   = 1'b1;
                    prod0_gnt_d = w_pick_sel[0];
                    prod1_gnt_d = w_pick_sel[1];
                    q_wdata_d   = w_pick_sel[1] ? prod1_data_in : prod0_data_in;
                    rr_ptr_d    = w_pick_sel[0];
                end else if (w_deq_elig) begin
                    state_d   = DEQ_ISSUE;
                    cur_op_d  = OP_DEQ;
                    dequeue_d = 1'b1;
                end else if (cons_req_in && !cons_ack_q) begin
                    // Empty queue: answer with an error; skip while the ack is still visible
                    cons_err_d  = 1'b1;
                    cons_ack_d  = 1'b1;
                    cons_data_d = '0;
                end
            end
            ENQ_ISSUE, DEQ_ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = WAIT_LOAD;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d   = IDLE;
                    last_op_d = cur_op_q;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                    // Registered here so the ack is visible during the final wait cycle
                    if ((wait_cnt_q == WAIT_CNT_W'(1)) && (cur_op_q == OP_DEQ)) begin
                        cons_ack_d  = 1'b1;
                        cons_data_d = q_data_in;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock_10KHz) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            last_op_q   <= 1'b0;
            cur_op_q    <= 1'b0;
            rr_ptr_q    <= 1'b0;
            enqueue_q   <= 1'b0;
            dequeue_q   <= 1'b0;
            q_wdata_q   <= '0;
            prod0_gnt_q <= 1'b0;
            prod1_gnt_q <= 1'b0;
            cons_ack_q  <= 1'b0;
            cons_err_q  <= 1'b0;
            cons_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            last_op_q   <= last_op_d;
            cur_op_q    <= cur_op_d;
            rr_ptr_q    <= rr_ptr_d;
            enqueue_q   <= enqueue_d;
            dequeue_q   <= dequeue_d;
            q_wdata_q   <= q_wdata_d;
            prod0_gnt_q <= prod0_gnt_d;
            prod1_gnt_q <= prod1_gnt_d;
            cons_ack_q  <= cons_ack_d;
            cons_err_q  <= cons_err_d;
            cons_data_q <= cons_data_d;
            busy_q      <= busy_d;
        end
    end

    assign enqueue_out   = enqueue_q;
    assign dequeue_out   = dequeue_q;
    assign q_wdata_out   = q_wdata_q;
    assign prod0_gnt_out = prod0_gnt_q;
    assign prod1_gnt_out = prod1_gnt_q;
    assign cons_ack_out  = cons_ack_q;
    assign cons_err_out  = cons_err_q;
    assign cons_data_out = cons_data_q;
    assign busy_out      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fila_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fila_arbiter                                              |
// | Description : Self-checking bench for fila_arbiter (FILA_ARB_RR_EN aware). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fila_arbiter;

`ifdef FILA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p0_req = 1'b0, p1_req = 1'b0, cons_req = 1'b0;
    logic [7:0] p0_data = '0, p1_data = '0, qdata = '0;
    logic [3:0] len = '0;

    logic       enqueue_out, dequeue_out, prod0_gnt_out, prod1_gnt_out;
    logic       cons_ack_out, cons_err_out, busy_out;
    logic [7:0] q_wdata_out, cons_data_out;

    int checks = 0;
    int errors = 0;

    // Reference model: an operation is a 4-cycle busy window after the deciding
    // edge; the window is released one edge after it ends.
    bit         m_active, m_is_deq, m_last_deq, m_pref1;
    int         m_age;
    logic       e_enq, e_deq, e_g0, e_g1, e_ack, e_err, e_busy;
    logic [7:0] e_wdata, e_cdata;

    always #5 clk = ~clk;

    fila_arbiter dut (
        .clock_10KHz   (clk),
        .reset         (rst_n),
        .prod0_req_in  (p0_req),
        .prod1_req_in  (p1_req),
        .prod0_data_in (p0_data),
        .prod1_data_in (p1_data),
        .cons_req_in   (cons_req),
        .len_in        (len),
        .q_data_in     (qdata),
        .enqueue_out   (enqueue_out),
        .dequeue_out   (dequeue_out),
        .q_wdata_out   (q_wdata_out),
        .prod0_gnt_out (prod0_gnt_out),
        .prod1_gnt_out (prod1_gnt_out),
        .cons_ack_out  (cons_ack_out),
        .cons_err_out  (cons_err_out),
        .cons_data_out (cons_data_out),
        .busy_out      (busy_out)
    );

    function automatic void model_edge();
        bit prev_ack, can_enq, can_deq, take1;
        prev_ack = e_ack;
        {e_enq, e_deq, e_g0, e_g1, e_ack, e_err} = '0;
        if (!rst_n) begin
            m_active = 0; m_last_deq = 0; m_pref1 = 0; m_age = 0;
            e_busy = 0; e_wdata = '0; e_cdata = '0;
            return;
        end
        if (m_active) begin
            m_age++;
            if (m_age == 3 && m_is_deq) begin
                e_ack = 1; e_cdata = qdata;
            end
            if (m_age == 4) begin
                m_active = 0; m_last_deq = m_is_deq;
            end
        end else begin
            can_enq = (p0_req || p1_req) && (len < 4'd8);
            can_deq = cons_req && (len != 4'd0);
            if (can_enq && (!can_deq || m_last_deq)) begin
                take1 = p1_req && (!p0_req || (RR && m_pref1));
                m_active = 1; m_is_deq = 0; m_age = 0;
                e_enq = 1; e_g0 = !take1; e_g1 = take1;
                e_wdata = take1 ? p1_data : p0_data;
                m_pref1 = !take1;
            end else if (can_deq) begin
                m_active = 1; m_is_deq = 1; m_age = 0;
                e_deq = 1;
            end else if (cons_req && !prev_ack) begin
                e_err = 1; e_ack = 1; e_cdata = '0;
            end
        end
        e_busy = m_active;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain(input int n);
        p0_req = 0; p1_req = 0; cons_req = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(); tick();
        checks++;
        if ({enqueue_out, dequeue_out, prod0_gnt_out, prod1_gnt_out, cons_ack_out, cons_err_out, busy_out} !== 7'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b required 0000000",
                     {enqueue_out, dequeue_out, prod0_gnt_out, prod1_gnt_out, cons_ack_out, cons_err_out, busy_out});
        end
        checks++;
        if ({q_wdata_out, cons_data_out} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got %h required 0000", {q_wdata_out, cons_data_out});
        end
        rst_n = 1;
    endtask

    task automatic test_enqueue();
        p0_req = 1; p0_data = 8'h41; len = 4'd0;
        tick();
        checks++;
        if ({enqueue_out, prod0_gnt_out, prod1_gnt_out, busy_out, q_wdata_out} !== {4'b1101, 8'h41}) begin
            errors++;
            $display("FAIL enq_issue got enq=%b g0=%b g1=%b busy=%b wdata=%h required 1 1 0 1 41",
                     enqueue_out, prod0_gnt_out, prod1_gnt_out, busy_out, q_wdata_out);
        end
        p0_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({enqueue_out, prod0_gnt_out, busy_out} !== 3'b001) begin
                errors++;
                $display("FAIL enq_wait%0d got enq=%b g0=%b busy=%b required 0 0 1", i, enqueue_out, prod0_gnt_out, busy_out);
            end
        end
        tick();
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL enq_done_busy got %b required 0", busy_out);
        end
    endtask

    task automatic test_dequeue();
        len = 4'd3; qdata = 8'h5A; cons_req = 1;
        tick();
        checks++;
        if ({dequeue_out, enqueue_out, busy_out} !== 3'b101) begin
            errors++;
            $display("FAIL deq_issue got deq=%b enq=%b busy=%b required 1 0 1", dequeue_out, enqueue_out, busy_out);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({dequeue_out, cons_ack_out} !== 2'b00) begin
                errors++;
                $display("FAIL deq_wait%0d got deq=%b ack=%b required 0 0", i, dequeue_out, cons_ack_out);
            end
        end
        tick();
        checks++;
        if ({cons_ack_out, cons_err_out, cons_data_out} !== {2'b10, 8'h5A}) begin
            errors++;
            $display("FAIL deq_ack got ack=%b err=%b data=%h required 1 0 5a", cons_ack_out, cons_err_out, cons_data_out);
        end
        cons_req = 0;
        tick();
        checks++;
        if ({busy_out, cons_ack_out} !== 2'b00) begin
            errors++;
            $display("FAIL deq_done got busy=%b ack=%b required 0 0", busy_out, cons_ack_out);
        end
    endtask

    task automatic test_empty_err();
        bit saw_deq = 0;
        len = 4'd0; cons_req = 1;
        tick();
        checks++;
        if ({cons_err_out, cons_ack_out, dequeue_out, busy_out, cons_data_out} !== {4'b1100, 8'h00}) begin
            errors++;
            $display("FAIL err_pulse got err=%b ack=%b deq=%b busy=%b data=%h required 1 1 0 0 00",
                     cons_err_out, cons_ack_out, dequeue_out, busy_out, cons_data_out);
        end
        saw_deq = dequeue_out;
        tick();
        checks++;
        if ({cons_err_out, cons_ack_out} !== 2'b00) begin
            errors++;
            $display("FAIL err_single got err=%b ack=%b required 0 0", cons_err_out, cons_ack_out);
        end
        saw_deq |= dequeue_out;
        cons_req = 0;
        tick();
        saw_deq |= dequeue_out;
        checks++;
        if (saw_deq !== 1'b0) begin
            errors++;
            $display("FAIL err_no_deq got %b required 0", saw_deq);
        end
    endtask

    task automatic test_full();
        len = 4'd8; p1_req = 1; p1_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({prod1_gnt_out, enqueue_out} !== 2'b00) begin
                errors++;
                $display("FAIL full_hold%0d got g1=%b enq=%b required 0 0", i, prod1_gnt_out, enqueue_out);
            end
        end
        len = 4'd7;
        tick();
        checks++;
        if ({prod1_gnt_out, prod0_gnt_out, enqueue_out, q_wdata_out} !== {3'b101, 8'h77}) begin
            errors++;
            $display("FAIL full_release got g1=%b g0=%b enq=%b wdata=%h required 1 0 1 77",
                     prod1_gnt_out, prod0_gnt_out, enqueue_out, q_wdata_out);
        end
        drain(5);
    endtask

    task automatic test_tie();
        int who;
        rst_n = 0; tick(); rst_n = 1;
        p0_req = 1; p1_req = 1; p0_data = 8'h11; p1_data = 8'h22; len = 4'd2;
        for (int k = 0; k < 4; k++) begin
            who = -1;
            for (int t = 0; t < 10 && who < 0; t++) begin
                tick();
                if (prod0_gnt_out && prod1_gnt_out) who = 2;
                else if (prod0_gnt_out) who = 0;
                else if (prod1_gnt_out) who = 1;
            end
            checks++;
            if (who != (RR ? (k % 2) : 0)) begin
                errors++;
                $display("FAIL tie_grant%0d got %0d required %0d (-1 timeout, 2 both)", k, who, RR ? (k % 2) : 0);
            end
        end
        drain(5);
    endtask

    task automatic test_reset_mid();
        bit saw_ack = 0;
        len = 4'd3; cons_req = 1; qdata = 8'hC3;
        tick();
        checks++;
        if (dequeue_out !== 1'b1) begin
            errors++;
            $display("FAIL rmid_deq got %b required 1", dequeue_out);
        end
        tick();
        rst_n = 0;
        tick();
        checks++;
        if ({enqueue_out, dequeue_out, prod0_gnt_out, prod1_gnt_out, cons_ack_out, cons_err_out, busy_out,
             q_wdata_out, cons_data_out} !== 23'h0) begin
            errors++;
            $display("FAIL rmid_outputs got busy=%b ack=%b deq=%b cdata=%h required all 0",
                     busy_out, cons_ack_out, dequeue_out, cons_data_out);
        end
        rst_n = 1; cons_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_ack |= cons_ack_out;
        end
        checks++;
        if (saw_ack !== 1'b0) begin
            errors++;
            $display("FAIL rmid_no_ack got %b required 0", saw_ack);
        end
    endtask

    task automatic test_random();
        logic [22:0] act, exp;
        rst_n = 0; drain(1); rst_n = 1;
        for (int c = 0; c < 900; c++) begin
            tick();
            act = {enqueue_out, dequeue_out, prod0_gnt_out, prod1_gnt_out, cons_ack_out, cons_err_out,
                   busy_out, q_wdata_out, cons_data_out};
            exp = {e_enq, e_deq, e_g0, e_g1, e_ack, e_err, e_busy, e_wdata, e_cdata};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL rnd_cycle%0d got %h required %h (enq,deq,g0,g1,ack,err,busy,wdata,cdata)", c, act, exp);
            end
            rst_n = ($urandom_range(0, 199) != 0);
            if (p0_req && (prod0_gnt_out || $urandom_range(0, 39) == 0)) p0_req = 0;
            else if (!p0_req && $urandom_range(0, 3) == 0) begin p0_req = 1; p0_data = 8'($urandom); end
            if (p1_req && (prod1_gnt_out || $urandom_range(0, 39) == 0)) p1_req = 0;
            else if (!p1_req && $urandom_range(0, 3) == 0) begin p1_req = 1; p1_data = 8'($urandom); end
            if (cons_req && (cons_ack_out || $urandom_range(0, 39) == 0)) cons_req = 0;
            else if (!cons_req && $urandom_range(0, 3) == 0) cons_req = 1;
            len   = 4'($urandom_range(0, 8));
            qdata = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enqueue();
        test_dequeue();
        test_empty_err();
        test_full();
        test_tie();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
